// File: rtl/piano_pkg.sv
// Shared constants for the piano key recorder: key ID defaults, sample layout and FSM states.
package piano_pkg;

  localparam int unsigned KeyIdBitsDefault = 4;
  localparam int unsigned KeyIdNone        = 0;

  // Flag bits sit directly above the key ID field; offsets are relative to KEY_ID_BITS.
  localparam int unsigned SmpPressedOfs = 0;
  localparam int unsigned SmpUpOfs      = 1;
  localparam int unsigned SmpDownOfs    = 2;
  localparam int unsigned SmpFlagBits   = 3;

  typedef logic [1:0] state_t;
  localparam state_t StIdle      = 2'd0;
  localparam state_t StRecording = 2'd1;
  localparam state_t StPlaying   = 2'd2;

  function automatic int unsigned sample_width(input int unsigned id_bits);
    return id_bits + SmpFlagBits;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level changes only after
// DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/piano_key_recorder.sv
// Piano front end: debounces keys and buttons, encodes the live key, records and replays samples.
// Define LOOP_PLAYBACK_EN for looping playback that a further playback press stops.
module piano_key_recorder import piano_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned NUM_KEYS           = 12,
  parameter int unsigned KEY_ID_BITS        = KeyIdBitsDefault,
  parameter int unsigned RECORD_INTERVAL_MS = 20,
  parameter int unsigned MAX_RECORD_SAMPLES = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_KEYS-1:0]    keys_in_raw,
  input  logic                   octave_up_raw,
  input  logic                   octave_down_raw,
  input  logic                   record_raw,
  input  logic                   playback_raw,
  output logic [KEY_ID_BITS-1:0] active_key_id,
  output logic                   key_is_pressed,
  output logic                   octave_up_db,
  output logic                   octave_down_db,
  output logic [KEY_ID_BITS-1:0] playback_key_id,
  output logic                   playback_key_is_pressed,
  output logic                   playback_octave_up,
  output logic                   playback_octave_down,
  output logic                   is_recording,
  output logic                   is_playing
);

  localparam int unsigned NumInputs      = NUM_KEYS + 4;
  localparam int unsigned IntervalCycles = CLK_FREQ_HZ / 1000 * RECORD_INTERVAL_MS;
  localparam int unsigned TickW          = (IntervalCycles > 1) ? $clog2(IntervalCycles) : 1;
  localparam int unsigned IdxW           = $clog2(MAX_RECORD_SAMPLES);
  localparam int unsigned AddrW          = IdxW + 1;
  localparam int unsigned SampleW        = sample_width(KEY_ID_BITS);

  logic [NumInputs-1:0] raw_vec, db_vec;
  logic [NUM_KEYS-1:0]  keys_db;
  logic                 rec_db, pb_db;

  assign raw_vec = {playback_raw, record_raw, octave_down_raw, octave_up_raw, keys_in_raw};

  for (genvar g = 0; g < NumInputs; g++) begin : gen_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i (clk),
      .rst_ni(rst_n),
      .raw_i (raw_vec[g]),
      .db_o  (db_vec[g])
    );
  end

  assign keys_db        = db_vec[NUM_KEYS-1:0];
  assign octave_up_db   = db_vec[NUM_KEYS];
  assign octave_down_db = db_vec[NUM_KEYS+1];
  assign rec_db         = db_vec[NUM_KEYS+2];
  assign pb_db          = db_vec[NUM_KEYS+3];

  logic [KEY_ID_BITS-1:0] scan_id, key_id_q;
  logic                   pressed_q;

  // Walk from the top so the lowest-index pressed key is the last to assign.
  always_comb begin
    scan_id = KEY_ID_BITS'(KeyIdNone);
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (keys_db[i]) scan_id = KEY_ID_BITS'(i + 1);
    end
  end

  logic               rec_prev_q, pb_prev_q, rec_rise, pb_pulse, tick, mem_we;
  state_t             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [AddrW-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, length_q, length_d;
  logic [SampleW-1:0] sample_w, rd_data_q;
  logic [SampleW-1:0] mem_q [MAX_RECORD_SAMPLES];

  assign rec_rise = rec_db & ~rec_prev_q;
  assign pb_pulse = pb_db & ~pb_prev_q;
  assign tick     = (tick_cnt_q == TickW'(IntervalCycles - 1));

  always_comb begin
    sample_w                                = '0;
    sample_w[KEY_ID_BITS-1:0]               = pressed_q ? key_id_q : KEY_ID_BITS'(KeyIdNone);
    sample_w[KEY_ID_BITS + SmpPressedOfs]   = pressed_q;
    sample_w[KEY_ID_BITS + SmpUpOfs]        = octave_up_db;
    sample_w[KEY_ID_BITS + SmpDownOfs]      = octave_down_db;
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    length_d   = length_q;
    mem_we     = 1'b0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        rd_addr_d = '0;
        if (rec_rise) begin
          state_d   = StRecording;
          wr_addr_d = '0;
        end else if (pb_pulse && (length_q != '0)) begin
          state_d = StPlaying;
        end
      end
      StRecording: begin
        if (!rec_db) begin
          state_d  = StIdle;
          length_d = wr_addr_q;
        end else if (tick && (wr_addr_q == AddrW'(MAX_RECORD_SAMPLES))) begin
          state_d  = StIdle;
          length_d = AddrW'(MAX_RECORD_SAMPLES);
        end else if ((tick_cnt_q == '0) && (wr_addr_q != AddrW'(MAX_RECORD_SAMPLES))) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      StPlaying: begin
`ifdef LOOP_PLAYBACK_EN
        if (pb_pulse) begin
          state_d = StIdle;
        end else if (tick) begin
          if (rd_addr_q == length_q - 1'b1) rd_addr_d = '0;
          else                              rd_addr_d = rd_addr_q + 1'b1;
        end
`else
        if (tick) begin
          if (rd_addr_q == length_q - 1'b1) state_d   = StIdle;
          else                              rd_addr_d = rd_addr_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) tick_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_id_q   <= '0;
      pressed_q  <= 1'b0;
      rec_prev_q <= 1'b0;
      pb_prev_q  <= 1'b0;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      length_q   <= '0;
    end else begin
      key_id_q   <= scan_id;
      pressed_q  <= |keys_db;
      rec_prev_q <= rec_db;
      pb_prev_q  <= pb_db;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      length_q   <= length_d;
    end
  end

  // Reading with the next-state address hides the RAM latency from the playback outputs.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q[IdxW-1:0]] <= sample_w;
    rd_data_q <= mem_q[rd_addr_d[IdxW-1:0]];
  end

  assign active_key_id           = key_id_q;
  assign key_is_pressed          = pressed_q;
  assign is_recording            = (state_q == StRecording);
  assign is_playing              = (state_q == StPlaying);
  assign playback_key_id         = is_playing ? rd_data_q[KEY_ID_BITS-1:0]
                                              : KEY_ID_BITS'(KeyIdNone);
  assign playback_key_is_pressed = is_playing & rd_data_q[KEY_ID_BITS + SmpPressedOfs];
  assign playback_octave_up      = is_playing & rd_data_q[KEY_ID_BITS + SmpUpOfs];
  assign playback_octave_down    = is_playing & rd_data_q[KEY_ID_BITS + SmpDownOfs];

endmodule

// File: tb/tb_piano_key_recorder.sv
// Randomised and directed bench for piano_key_recorder against a cycle-level behavioural model.
module tb_piano_key_recorder;

  localparam int unsigned D    = 4;
  localparam int unsigned I    = 5;
  localparam int unsigned MAXS = 8;
  localparam int unsigned NK   = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] keys;
  logic        up, down, rec, pb;
  logic [3:0]  active_key_id, playback_key_id;
  logic        key_is_pressed, octave_up_db, octave_down_db;
  logic        playback_key_is_pressed, playback_octave_up, playback_octave_down;
  logic        is_recording, is_playing;

  always #5 clk = ~clk;

  piano_key_recorder #(
    .CLK_FREQ_HZ       (1000),
    .DEBOUNCE_CYCLES   (D),
    .NUM_KEYS          (NK),
    .KEY_ID_BITS       (4),
    .RECORD_INTERVAL_MS(5),
    .MAX_RECORD_SAMPLES(MAXS)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .keys_in_raw            (keys),
    .octave_up_raw          (up),
    .octave_down_raw        (down),
    .record_raw             (rec),
    .playback_raw           (pb),
    .active_key_id          (active_key_id),
    .key_is_pressed         (key_is_pressed),
    .octave_up_db           (octave_up_db),
    .octave_down_db         (octave_down_db),
    .playback_key_id        (playback_key_id),
    .playback_key_is_pressed(playback_key_is_pressed),
    .playback_octave_up     (playback_octave_up),
    .playback_octave_down   (playback_octave_down),
    .is_recording           (is_recording),
    .is_playing             (is_playing)
  );

  int errors = 0;
  int checks = 0;
  int play_cnt, rec_cnt, press_cnt;

  // Model state: raw history bits are {pb, rec, down, up, keys[11:0]}.
  logic [15:0] m_hist [0:D+1];
  logic [15:0] m_db, m_db_prev;
  logic [3:0]  m_id;
  logic        m_pr;
  int          m_mode;  // 0 idle, 1 recording, 2 playing
  int          m_phase, m_len;
  logic [6:0]  m_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) m_hist[k] = '0;
    m_db = '0; m_db_prev = '0; m_id = '0; m_pr = 1'b0;
    m_mode = 0; m_phase = 0; m_len = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [15:0] raw);
    logic [15:0] mask;
    logic        rec_db, rec_rise, pb_pulse;
    logic [6:0]  smp;
    rec_db   = m_db[14];
    rec_rise = m_db[14] & ~m_db_prev[14];
    pb_pulse = m_db[15] & ~m_db_prev[15];
    smp      = {m_db[13], m_db[12], m_pr, m_pr ? m_id : 4'd0};
    case (m_mode)
      0: begin
        if (rec_rise) begin
          m_mode = 1; m_phase = 0; m_q.delete();
        end else if (pb_pulse && m_len > 0) begin
          m_mode = 2; m_phase = 0;
        end
      end
      1: begin
        if (!rec_db) begin
          m_mode = 0; m_len = m_q.size();
        end else if (m_phase == int'(MAXS * I) - 1) begin
          m_mode = 0; m_len = MAXS;
        end else begin
          if (m_phase % I == 0 && m_q.size() < MAXS) m_q.push_back(smp);
          m_phase++;
        end
      end
      default: begin
`ifdef LOOP_PLAYBACK_EN
        if (pb_pulse) m_mode = 0;
        else if (m_phase == m_len * I - 1) m_phase = 0;
        else m_phase++;
`else
        if (m_phase == m_len * I - 1) m_mode = 0;
        else m_phase++;
`endif
      end
    endcase
    m_id = 4'd0;
    for (int k = 0; k < NK; k++) begin
      if (m_db[k]) begin
        m_id = 4'(k + 1);
        break;
      end
    end
    m_pr = (m_id != 4'd0);
    // A level flips once the last D synchronised samples all disagree with it.
    mask = 16'hFFFF;
    for (int k = 0; k < D; k++) mask &= (m_hist[k + 1] ^ m_db);
    m_db_prev = m_db;
    m_db      = m_db ^ mask;
    for (int k = D + 1; k > 0; k--) m_hist[k] = m_hist[k - 1];
    m_hist[0] = raw;
  endtask

  task automatic cycle();
    logic [6:0] exp_pb;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step({pb, rec, down, up, keys});
    @(negedge clk);
    exp_pb = (m_mode == 2) ? m_q[m_phase / I] : 7'd0;
    chk("live_id", active_key_id, m_id);
    chk("live_pressed", key_is_pressed, m_pr);
    chk("octave_db", {octave_down_db, octave_up_db}, m_db[13:12]);
    chk("is_recording", is_recording, m_mode == 1);
    chk("is_playing", is_playing, m_mode == 2);
    chk("pb_sample", {playback_octave_down, playback_octave_up, playback_key_is_pressed,
                      playback_key_id}, exp_pb);
    if (is_playing)     play_cnt++;
    if (is_recording)   rec_cnt++;
    if (key_is_pressed) press_cnt++;
  endtask

  task automatic hold(input logic [11:0] k, input logic u, input logic d, input logic r,
                      input logic p, input int n);
    keys = k; up = u; down = d; rec = r; pb = p;
    repeat (n) cycle();
  endtask

  task automatic wait_playing(input int bound);
    int n = 0;
    while (!is_playing && n < bound) begin
      cycle();
      n++;
    end
    chk("play_start", is_playing, 1'b1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    hold(12'h000, 0, 0, 0, 0, 3);
    rst_n = 1'b1;
    chk("reset_outputs", {active_key_id, key_is_pressed, octave_up_db, octave_down_db,
                          playback_key_id, playback_key_is_pressed, playback_octave_up,
                          playback_octave_down, is_recording, is_playing}, 16'h0);

    // Short glitch must never reach the scanner.
    press_cnt = 0;
    hold(12'h004, 0, 0, 0, 0, 3);
    hold(12'h000, 0, 0, 0, 0, 10);
    chk("glitch_no_press", press_cnt, 0);

    keys = 12'h004;
    repeat (6) cycle();
    chk("key3_before_7", key_is_pressed, 1'b0);
    cycle();
    chk("key3_id_at_7", active_key_id, 4'd3);
    chk("key3_pressed_at_7", key_is_pressed, 1'b1);
    hold(12'h004, 0, 0, 0, 0, 3);
    hold(12'h000, 0, 0, 0, 0, 10);

    hold(12'h012, 0, 0, 0, 0, 10);
    chk("two_keys_id", active_key_id, 4'd2);
    hold(12'h010, 0, 0, 0, 0, 10);
    chk("release_bit1_id", active_key_id, 4'd5);
    hold(12'h000, 0, 0, 0, 0, 10);

    // Record 15 cycles of key 1 with octave up, then replay.
    hold(12'h001, 1, 0, 0, 0, 10);
    hold(12'h001, 1, 0, 1, 0, 15);
    hold(12'h000, 0, 0, 0, 0, 12);
    play_cnt = 0;
    keys = '0; up = 0; down = 0; rec = 0; pb = 1;
    wait_playing(20);
    chk("play_sample_key1", {playback_octave_down, playback_octave_up, playback_key_is_pressed,
                             playback_key_id}, 7'b011_0001);
    hold(12'h000, 0, 0, 0, 0, 40);
    chk("play_len3_cycles", play_cnt, 15);
    chk("after_play_zero", {playback_key_id, playback_key_is_pressed, playback_octave_up}, 0);

    // Held record saturates at MAX samples.
    rec_cnt = 0;
    hold(12'h000, 0, 0, 1, 0, 60);
    hold(12'h000, 0, 0, 0, 0, 10);
    chk("rec_max_cycles", rec_cnt, 40);
    play_cnt = 0;
    hold(12'h000, 0, 0, 0, 1, 8);
    hold(12'h000, 0, 0, 0, 0, 50);
    chk("play_len8_cycles", play_cnt, 40);

    // Record and playback rising together: record wins.
    hold(12'h000, 0, 0, 1, 1, 10);
    chk("rec_wins_rec", is_recording, 1'b1);
    chk("rec_wins_play", is_playing, 1'b0);
    hold(12'h000, 0, 0, 0, 0, 15);

    // Reset during playback clears length.
    pb = 1;
    wait_playing(20);
    hold(12'h000, 0, 0, 0, 0, 3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("reset_mid_play", {is_playing, playback_key_id, playback_key_is_pressed,
                           playback_octave_up, playback_octave_down}, 0);
    play_cnt = 0;
    hold(12'h000, 0, 0, 0, 1, 8);
    hold(12'h000, 0, 0, 0, 0, 20);
    chk("pb_len0_ignored", play_cnt, 0);

    // Random soak.
    rec = 0;
    repeat (300) begin
      logic [11:0] rk;
      logic        rr;
      rk = 12'($urandom_range(0, 4095) & $urandom_range(0, 4095) & $urandom_range(0, 4095));
      rr = ($urandom_range(0, 5) == 0) ? ~rec : rec;
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
      hold(rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rr,
           ($urandom_range(0, 3) == 0), $urandom_range(1, 14));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piano_key_recorder.md
Name: piano_key_recorder

Overview:
- Front-end input and recording block for the FPGA piano.
- Debounces 12 musical keys, octave up/down, record and playback buttons.
- Priority-encodes the musical keys into a live key ID.
- Records live samples into on-chip memory at a fixed interval and replays them on request. The downstream tone generator and display mux between live and playback outputs.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock frequency.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level (20 ms).
- NUM_KEYS, 12, musical key count; IDs 1..NUM_KEYS.
- KEY_ID_BITS, 4, key ID width; must satisfy 2^KEY_ID_BITS > NUM_KEYS.
- RECORD_INTERVAL_MS, 20, sample period; INTERVAL_CYCLES = CLK_FREQ_HZ/1000*RECORD_INTERVAL_MS.
- MAX_RECORD_SAMPLES, 512, sample memory depth.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- keys_in_raw  in  NUM_KEYS  raw musical keys, active high; bit i gives ID i+1.
- octave_up_raw  in  1  raw octave-up button.
- octave_down_raw  in  1  raw octave-down button.
- record_raw  in  1  raw record button (level).
- playback_raw  in  1  raw playback button (edge).
- active_key_id  out  KEY_ID_BITS  live key ID, 0 = none.
- key_is_pressed  out  1  live key pressed.
- octave_up_db / octave_down_db  out  1 each  debounced octave levels.
- playback_key_id  out  KEY_ID_BITS  replayed key ID.
- playback_key_is_pressed  out  1  replayed pressed flag.
- playback_octave_up / playback_octave_down  out  1 each  replayed octave bits.
- is_recording  out  1  in RECORDING state.
- is_playing  out  1  in PLAYING state.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, all debounced levels 0, FSM IDLE, recorded_length 0. Memory contents are don't-care.
- Debounce (every raw input):
  - 2-FF synchronizer feeds a counter.
  - While the synced value differs from the debounced value, the counter increments; it clears on any match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - Total latency from a clean raw edge is DEBOUNCE_CYCLES+2 cycles. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Scanner (registered, 1 cycle after debounced keys):
  - Lowest-index pressed key wins: active_key_id = index+1, key_is_pressed = 1.
  - No key pressed: active_key_id = 0, key_is_pressed = 0.
- Sample format: {down, up, pressed, id}. id is forced to 0 when not pressed. Both octave bits are stored as-is; interpreting both set as middle octave is downstream's job.
- Playback pulse: one cycle, generated on the rising edge of debounced playback.
- Interval tick: counter wraps at INTERVAL_CYCLES-1. It restarts at 0 on every FSM state entry.
- FSM IDLE:
  - Debounced record rising from 0 to 1 → RECORDING with wr_addr = 0.
  - Otherwise, playback pulse with recorded_length > 0 → PLAYING with rd_addr = 0.
  - Record wins if both events occur in the same cycle.
  - Playback pulse with length 0 is ignored.
- FSM RECORDING (is_recording=1):
  - Sample 0 is written on the entry cycle, then one sample per tick, with wr_addr incrementing.
  - Record released → IDLE, recorded_length = wr_addr.
  - wr_addr reaching MAX_RECORD_SAMPLES → IDLE, length = MAX. Record must then be released and re-pressed to record again.
  - Playback pulses are ignored.
- FSM PLAYING (is_playing=1):
  - Playback outputs present mem[rd_addr] from the entry cycle (1-cycle read latency absorbed by prefetch).
  - rd_addr advances every tick.
  - After the last sample's interval → IDLE; playback outputs return to 0.
  - Record presses and further playback pulses are ignored while playing.
- Live outputs always track the keys, in every state.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- Defined: at end of the recording, PLAYING wraps rd_addr to 0 and continues. A playback pulse while PLAYING stops playback → IDLE.
- Undefined: single-pass playback as above; pulses during PLAYING are ignored.

Decomposition:
- Package piano_pkg holds:
  - KEY_ID_BITS default;
  - sample field widths and offsets;
  - FSM state enum {IDLE, RECORDING, PLAYING};
  - ID 0 = none constant.
- One sub-module, key_debounce: synchronizer plus counter, parameter DEBOUNCE_CYCLES, instantiated once per raw input (16 instances).

Test Plan (DEBOUNCE_CYCLES=4, CLK_FREQ_HZ=1000, RECORD_INTERVAL_MS=5 → 5 cycles, MAX_RECORD_SAMPLES=8):
- keys_in_raw bit 2 held high for 3 cycles, then low → active_key_id stays 0. Held 10 cycles → active_key_id=3, key_is_pressed=1 by cycle 7.
- Bits 4 and 1 held high → active_key_id=2. Release bit 1 → 5.
- Record 15 cycles with key 1 (ID 1) and octave_up → length 3. Playback press → is_playing for 15 cycles; outputs ID 1, pressed, up=1 during that time; then all 0.
- Record held 60 cycles → is_recording drops after 8 samples (40 cycles), length=8. A further record press is needed to restart.
- Playback press with length 0 → is_playing stays 0. Record and playback debounced-rising in the same cycle → RECORDING.
- rst_n low mid-PLAYING → next cycle is_playing=0, outputs 0. Subsequent playback press ignored (length 0).
